video_out_stage: RTL and testbench



---
 rtl/video_out_if.sv | 33 +++
 rtl/video_out_stage.sv | 156 +++++++++++++++
 tb/tb_video_out_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_out_if.sv
// Video output stage signal bundle: core-side RGB/sync/clock-enable inputs and
// DAC-side expanded RGB, delayed syncs and line measurement outputs.
interface video_out_if #(
  parameter int IW  = 3,
  parameter int OW  = 6,
  parameter int HCW = 11
);
  logic           clken;
  logic [IW-1:0]  ri;
  logic [IW-1:0]  gi;
  logic [IW-1:0]  bi;
  logic           hsync_n;
  logic           vsync_n;
  logic           scanlines_enable;
  logic [OW-1:0]  r;
  logic [OW-1:0]  g;
  logic [OW-1:0]  b;
  logic           hsync;
  logic           vsync;
  logic           line_odd;
  logic [HCW-1:0] hlen;
  logic           locked;

  modport master (
    output clken, ri, gi, bi, hsync_n, vsync_n, scanlines_enable,
    input  r, g, b, hsync, vsync, line_odd, hlen, locked
  );

  modport slave (
    input  clken, ri, gi, bi, hsync_n, vsync_n, scanlines_enable,
    output r, g, b, hsync, vsync, line_odd, hlen, locked
  );
endinterface

// File: rtl/video_out_stage.sv
// Video output stage: bit-replicated colour expansion, 2-cycle sync-matched
// pipeline with blanking, line parity and hsync period lock detection.
// Scanline dimming is built only when VIDEO_OUT_SCANLINES_EN is defined.
module video_out_stage #(
  parameter int IW        = 3,
  parameter int OW        = 6,
  parameter int DIM_SHIFT = 1,
  parameter int HCW       = 11
) (
  input logic       clk,
  input logic       reset,
  video_out_if.slave vif
);

  localparam logic [HCW-1:0] HMAX = '1;

  function automatic logic [OW-1:0] expand(input logic [IW-1:0] c);
    logic [OW-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < OW; i++) e[OW-1-i] = c[IW-1-(i % IW)];
    return e;
  endfunction

  logic [OW-1:0]  r1_q, g1_q, b1_q, r1_d, g1_d, b1_d;
  logic           hs1_q, vs1_q, hs1_d, vs1_d;
  logic [OW-1:0]  r_q, g_q, b_q, r_d, g_d, b_d;
  logic           hsync_q, vsync_q, hsync_d, vsync_d;
  logic           hs_prev_q, vs_prev_q, hs_prev_d, vs_prev_d;
  logic           line_odd_q, line_odd_d;
  logic [HCW-1:0] hcnt_q, hcnt_d, hlen_q, hlen_d, cap;
  logic           first_seen_q, first_seen_d, locked_q, locked_d;
  logic [1:0]     match_q, match_d;
  logic           hs_fall, vs_fall, timeout;

  always_comb begin
    r1_d    = expand(vif.ri);
    g1_d    = expand(vif.gi);
    b1_d    = expand(vif.bi);
    hs1_d   = vif.hsync_n;
    vs1_d   = vif.vsync_n;
    hsync_d = hs1_q;
    vsync_d = vs1_q;
    r_d     = r1_q;
    g_d     = g1_q;
    b_d     = b1_q;
    if (!hs1_q || !vs1_q) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
`ifdef VIDEO_OUT_SCANLINES_EN
    else if (vif.scanlines_enable && line_odd_q) begin
      r_d = r1_q - (r1_q >> DIM_SHIFT);
      g_d = g1_q - (g1_q >> DIM_SHIFT);
      b_d = b1_q - (b1_q >> DIM_SHIFT);
    end
`endif
  end

`ifndef VIDEO_OUT_SCANLINES_EN
  logic unused_ok;
  assign unused_ok = vif.scanlines_enable ^ (DIM_SHIFT == 0);
`endif

  assign hs_fall = vif.clken & hs_prev_q & ~vif.hsync_n;
  assign vs_fall = vif.clken & vs_prev_q & ~vif.vsync_n;
  assign timeout = (hcnt_q == HMAX);
  assign cap     = hcnt_q + 1'b1;

  always_comb begin
    hs_prev_d    = hs_prev_q;
    vs_prev_d    = vs_prev_q;
    hcnt_d       = hcnt_q;
    hlen_d       = hlen_q;
    first_seen_d = first_seen_q;
    match_d      = match_q;
    locked_d     = locked_q;
    line_odd_d   = line_odd_q;
    if (vif.clken) begin
      hs_prev_d = vif.hsync_n;
      vs_prev_d = vif.vsync_n;
      if (!timeout) hcnt_d = hcnt_q + 1'b1;
    end
    if (timeout) begin
      locked_d     = 1'b0;
      match_d      = '0;
      first_seen_d = 1'b0;
    end
    // An edge coinciding with timeout starts a fresh measurement, not a capture.
    if (hs_fall) begin
      hcnt_d = '0;
      if (!first_seen_q || timeout) begin
        first_seen_d = 1'b1;
      end else begin
        hlen_d = cap;
        if (cap == hlen_q) match_d = (match_q == 2'd2) ? 2'd2 : match_q + 2'd1;
        else               match_d = '0;
        locked_d = (match_d == 2'd2);
      end
    end
    if (vs_fall)      line_odd_d = 1'b0;
    else if (hs_fall) line_odd_d = ~line_odd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q         <= '0;
      g1_q         <= '0;
      b1_q         <= '0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      line_odd_q   <= 1'b0;
      hcnt_q       <= '0;
      hlen_q       <= '0;
      first_seen_q <= 1'b0;
      match_q      <= '0;
      locked_q     <= 1'b0;
    end else begin
      r1_q         <= r1_d;
      g1_q         <= g1_d;
      b1_q         <= b1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      line_odd_q   <= line_odd_d;
      hcnt_q       <= hcnt_d;
      hlen_q       <= hlen_d;
      first_seen_q <= first_seen_d;
      match_q      <= match_d;
      locked_q     <= locked_d;
    end
  end

  assign vif.r        = r_q;
  assign vif.g        = g_q;
  assign vif.b        = b_q;
  assign vif.hsync    = hsync_q;
  assign vif.vsync    = vsync_q;
  assign vif.line_odd = line_odd_q;
  assign vif.hlen     = hlen_q;
  assign vif.locked   = locked_q;

endmodule

// File: tb/tb_video_out_stage.sv
// Self-checking bench for video_out_stage: randomized RGB and clock-enable
// gaps against a behavioural model, plus directed expansion/lock/timeout steps.
module tb_video_out_stage;

  localparam int IW        = 3;
  localparam int OW        = 6;
  localparam int DIM_SHIFT = 1;
  localparam int HCW       = 11;
  localparam int HMAX      = (1 << HCW) - 1;
`ifdef VIDEO_OUT_SCANLINES_EN
  localparam bit SCAN_BUILD = 1'b1;
`else
  localparam bit SCAN_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  video_out_if #(.IW(IW), .OW(OW), .HCW(HCW)) vif ();

  video_out_stage #(.IW(IW), .OW(OW), .DIM_SHIFT(DIM_SHIFT), .HCW(HCW)) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  typedef struct {
    int r, g, b;
    bit hs, vs, lodd;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  bit   rand_rgb = 1'b0;
  int   max_gap  = 0;

  ent_t m_prev;
  int   e_r, e_g, e_b;
  bit   e_hs, e_vs;
  bit   m_lodd, m_locked, m_seen, m_to, m_hs_prev, m_vs_prev;
  int   m_hlen, m_match, m_since;

  function automatic int expand_ref(int c);
    int acc  = 0;
    int bits = 0;
    while (bits < OW) begin
      acc  = (acc << IW) | c;
      bits = bits + IW;
    end
    return acc >> (bits - OW);
  endfunction

  function automatic int out_ref(int c, bit hs, bit vs, bit lodd, bit scan);
    if (!hs || !vs)    return 0;
    if (scan && lodd)  return c - c / (1 << DIM_SHIFT);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit hf, vf, scan;
    if (reset) begin
      e_r = 0; e_g = 0; e_b = 0; e_hs = 1'b1; e_vs = 1'b1;
      m_prev = '{r: 0, g: 0, b: 0, hs: 1'b1, vs: 1'b1, lodd: 1'b0};
      m_lodd = 1'b0; m_hlen = 0; m_locked = 1'b0; m_match = 0;
      m_seen = 1'b0; m_since = 0; m_to = 1'b0; m_hs_prev = 1'b1; m_vs_prev = 1'b1;
      return;
    end
    scan = SCAN_BUILD && vif.scanlines_enable;
    e_r  = out_ref(m_prev.r, m_prev.hs, m_prev.vs, m_prev.lodd, scan);
    e_g  = out_ref(m_prev.g, m_prev.hs, m_prev.vs, m_prev.lodd, scan);
    e_b  = out_ref(m_prev.b, m_prev.hs, m_prev.vs, m_prev.lodd, scan);
    e_hs = m_prev.hs;
    e_vs = m_prev.vs;
    if (m_to) begin
      m_locked = 1'b0; m_match = 0; m_seen = 1'b0;
    end
    if (vif.clken) begin
      hf = m_hs_prev && !vif.hsync_n;
      vf = m_vs_prev && !vif.vsync_n;
      m_hs_prev = vif.hsync_n;
      m_vs_prev = vif.vsync_n;
      m_since++;
      if (hf) begin
        if (!m_seen) m_seen = 1'b1;
        else begin
          m_match  = (m_since == m_hlen) ? ((m_match >= 2) ? 2 : m_match + 1) : 0;
          m_hlen   = m_since;
          m_locked = (m_match == 2);
        end
        m_since = 0;
        m_to    = 1'b0;
      end else if (m_since >= HMAX) begin
        m_to = 1'b1;
      end
      if (vf)      m_lodd = 1'b0;
      else if (hf) m_lodd = !m_lodd;
    end
    m_prev = '{r: expand_ref(int'(vif.ri)), g: expand_ref(int'(vif.gi)),
               b: expand_ref(int'(vif.bi)), hs: vif.hsync_n, vs: vif.vsync_n, lodd: m_lodd};
  endtask

  task automatic step();
    if (rand_rgb) begin
      vif.ri = IW'($urandom);
      vif.gi = IW'($urandom);
      vif.bi = IW'($urandom);
    end
    @(posedge clk);
    model_update();
    #1;
    chk("r", vif.r, e_r);
    chk("g", vif.g, e_g);
    chk("b", vif.b, e_b);
    chk("hsync", vif.hsync, e_hs);
    chk("vsync", vif.vsync, e_vs);
    chk("line_odd", vif.line_odd, m_lodd);
    chk("hlen", vif.hlen, m_hlen);
    chk("locked", vif.locked, m_locked);
  endtask

  task automatic ctick();
    int gap;
    gap = $urandom_range(0, max_gap);
    vif.clken = 1'b0;
    repeat (gap) step();
    vif.clken = 1'b1;
    step();
  endtask

  task automatic run_line(input int p);
    bit vpulse;
    vpulse = ($urandom_range(0, 3) == 0);
    vif.scanlines_enable = $urandom_range(0, 1);
    for (int t = 0; t < p; t++) begin
      vif.hsync_n = (t < 4) ? 1'b0 : 1'b1;
      vif.vsync_n = (vpulse && t >= 10 && t < 14) ? 1'b0 : 1'b1;
      ctick();
    end
    vif.vsync_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_r"}, vif.r, 0);
    chk({tag, "_g"}, vif.g, 0);
    chk({tag, "_b"}, vif.b, 0);
    chk({tag, "_hsync"}, vif.hsync, 1);
    chk({tag, "_vsync"}, vif.vsync, 1);
    chk({tag, "_line_odd"}, vif.line_odd, 0);
    chk({tag, "_hlen"}, vif.hlen, 0);
    chk({tag, "_locked"}, vif.locked, 0);
  endtask

  initial begin
    reset = 1'b1;
    vif.clken = 1'b0; vif.ri = '0; vif.gi = '0; vif.bi = '0;
    vif.hsync_n = 1'b1; vif.vsync_n = 1'b1; vif.scanlines_enable = 1'b0;
    step();
    step();
    chk_reset_state("reset");
    reset = 1'b0;

    // Expansion and 2-cycle latency
    vif.ri = 3'b101; vif.gi = 3'b111; vif.bi = 3'b000;
    vif.clken = 1'b1; step();
    chk("lat1_r", vif.r, 0);
    vif.clken = 1'b0; step();
    chk("exp_r", vif.r, 6'b101101);
    chk("exp_g", vif.g, 6'b111111);
    chk("exp_b", vif.b, 6'b000000);

    // One-cycle hsync blanking
    vif.ri = 3'b111; vif.gi = 3'b111; vif.bi = 3'b111;
    step();
    vif.hsync_n = 1'b0; step();
    vif.hsync_n = 1'b1; step();
    chk("blank_r", vif.r, 0);
    chk("blank_g", vif.g, 0);
    chk("blank_hsync", vif.hsync, 0);
    step();
    chk("unblank_r", vif.r, 63);

    // Scanline dimming on an odd line
    vif.scanlines_enable = 1'b1;
    vif.clken = 1'b1; vif.hsync_n = 1'b0; step();
    vif.clken = 1'b0; vif.hsync_n = 1'b1;
    chk("scan_line_odd", vif.line_odd, 1);
    vif.ri = 3'b101; step(); step();
    chk("scan_r101", vif.r, SCAN_BUILD ? 23 : 45);
    vif.ri = 3'b111; step(); step();
    chk("scan_r111", vif.r, SCAN_BUILD ? 32 : 63);
    vif.scanlines_enable = 1'b0; step(); step();
    chk("noscan_r111", vif.r, 63);
    vif.ri = 3'b101; step(); step();
    chk("noscan_r101", vif.r, 45);

    // Lock acquisition and mismatch with random RGB and clken gaps
    rand_rgb = 1'b1; max_gap = 1;
    reset = 1'b1; step(); reset = 1'b0;
    run_line(896); run_line(896);
    chk("lock_e2_hlen", vif.hlen, 896);
    chk("lock_e2_locked", vif.locked, 0);
    run_line(896); run_line(896);
    chk("lock_e4_hlen", vif.hlen, 896);
    chk("lock_e4_locked", vif.locked, 1);
    run_line(900);
    vif.hsync_n = 1'b0;
    repeat (4) ctick();
    chk("mis_hlen", vif.hlen, 900);
    chk("mis_locked", vif.locked, 0);
    vif.hsync_n = 1'b1;
    repeat (892) ctick();
    run_line(896); run_line(896); run_line(896);
    chk("relock_locked", vif.locked, 1);

    // Timeout: no hsync edge for longer than the counter range
    vif.hsync_n = 1'b1;
    repeat (2100) ctick();
    chk("to_locked", vif.locked, 0);
    chk("to_hlen", vif.hlen, 896);

    // First edge after timeout does not capture; simultaneous edges clear parity
    if (!m_lodd) begin
      vif.hsync_n = 1'b0; repeat (2) ctick();
      vif.hsync_n = 1'b1; repeat (2) ctick();
      chk("post_to_hlen", vif.hlen, 896);
    end
    chk("pre_both_line_odd", vif.line_odd, 1);
    vif.hsync_n = 1'b0; vif.vsync_n = 1'b0; ctick();
    chk("both_line_odd", vif.line_odd, 0);
    vif.hsync_n = 1'b1; vif.vsync_n = 1'b1; repeat (3) ctick();

    // Reset mid-line while locked
    run_line(896); run_line(896); run_line(896); run_line(896);
    chk("pre_rst_locked", vif.locked, 1);
    vif.hsync_n = 1'b0; repeat (4) ctick();
    vif.hsync_n = 1'b1; repeat (300) ctick();
    reset = 1'b1; vif.clken = 1'b1; step(); reset = 1'b0;
    chk_reset_state("midrst");
    run_line(896); run_line(896); run_line(896);
    chk("rst_e3_locked", vif.locked, 0);
    run_line(896);
    chk("rst_e4_locked", vif.locked, 1);
    chk("rst_e4_hlen", vif.hlen, 896);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
